ahb_des_slave: RTL and testbench

// - AHB-Lite slave front-end for the Triple-DES core. It decodes bus transfers into key, data and control

---
 rtl/ahb_des_slave.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_des_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_des_slave.sv
// AHB-Lite slave front-end for the Triple-DES core: register decode, start pulse
// generation and result capture, with bounded wait states on DATA_OUT reads.
module ahb_des_slave #(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 64
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [63:0]       HWDATA,
  output logic [63:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [63:0]       des_key1,
  output logic [63:0]       des_key2,
  output logic [63:0]       des_key3,
  output logic [63:0]       des_data_in,
  output logic              des_decrypt,
  output logic              des_start,
  input  logic [63:0]       des_data_out,
  input  logic              des_done
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(6'h00);
  localparam logic [ADDR_W-1:0] A_KEY1 = ADDR_W'(6'h08);
  localparam logic [ADDR_W-1:0] A_KEY2 = ADDR_W'(6'h10);
  localparam logic [ADDR_W-1:0] A_KEY3 = ADDR_W'(6'h18);
  localparam logic [ADDR_W-1:0] A_DIN  = ADDR_W'(6'h20);
  localparam logic [ADDR_W-1:0] A_DOUT = ADDR_W'(6'h28);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(6'h30);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OK   = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s, tgt_s;
  logic [CW-1:0]     wait_cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r, rd_addr_s;
  logic              write_r, rd_write_s;
  logic [63:0]       key1_r, key2_r, key3_r, din_r, dout_r, hrdata_r;
  logic [63:0]       key1_nxt_s, key2_nxt_s, key3_nxt_s, din_nxt_s, dout_nxt_s, hrdata_nxt_s;
  logic              decrypt_r, busy_r, valid_r, sticky_r, start_r, hreadyout_r, hresp_r;
  logic              decrypt_nxt_s, busy_nxt_s, valid_nxt_s, sticky_nxt_s, start_nxt_s;
  logic              acc_s, err_a_s, wr_en_s, stat_rd_s, capture_s, unused_s;

  // Transfers are only taken in states that can end a data phase with HREADYOUT high.
  assign acc_s      = HSEL && HREADY && HTRANS[1] && (state_r != ST_WAIT) && (state_r != ST_ERR1);
  assign wr_en_s    = (state_r == ST_OK) && write_r;
  assign stat_rd_s  = (state_r == ST_OK) && !write_r && (addr_r == A_STAT);
  assign capture_s  = des_done && busy_r;
  assign rd_addr_s  = acc_s ? HADDR : addr_r;
  assign rd_write_s = acc_s ? HWRITE : write_r;
  assign unused_s   = HTRANS[0];

  // Busy is taken from its next value so a start landing this cycle already blocks writes.
  assign err_a_s = (HSIZE != 3'b011) || (HADDR[2:0] != 3'b000) || (HADDR > A_STAT) ||
                   (HWRITE && (busy_nxt_s || (HADDR >= A_DOUT)));
  assign tgt_s   = err_a_s ? ST_ERR1 :
                   ((!HWRITE && (HADDR == A_DOUT) && busy_nxt_s) ? ST_WAIT : ST_OK);

  // Write-data register next values from a completing, error-free write data phase.
  always_comb begin
    key1_nxt_s    = key1_r;
    key2_nxt_s    = key2_r;
    key3_nxt_s    = key3_r;
    din_nxt_s     = din_r;
    decrypt_nxt_s = decrypt_r;
    start_nxt_s   = 1'b0;
    if (wr_en_s) begin
      case (addr_r)
        A_CTRL: begin
          decrypt_nxt_s = HWDATA[1];
          start_nxt_s   = HWDATA[0];
        end
        A_KEY1:  key1_nxt_s = HWDATA;
        A_KEY2:  key2_nxt_s = HWDATA;
        A_KEY3:  key3_nxt_s = HWDATA;
        A_DIN:   din_nxt_s  = HWDATA;
        default: start_nxt_s = 1'b0;
      endcase
    end else begin
      start_nxt_s = 1'b0;
    end
  end

  // Core status tracking: start, result capture and sticky error flag.
  always_comb begin
    busy_nxt_s   = busy_r;
    valid_nxt_s  = valid_r;
    sticky_nxt_s = sticky_r;
    if (start_nxt_s) begin
      busy_nxt_s  = 1'b1;
      valid_nxt_s = 1'b0;
    end else if (capture_s) begin
      busy_nxt_s  = 1'b0;
      valid_nxt_s = 1'b1;
    end else begin
      busy_nxt_s  = busy_r;
      valid_nxt_s = valid_r;
    end
    dout_nxt_s = capture_s ? des_data_out : dout_r;
    if (state_r == ST_ERR1) begin
      sticky_nxt_s = 1'b1;
    end else if (stat_rd_s) begin
      sticky_nxt_s = 1'b0;
    end else begin
      sticky_nxt_s = sticky_r;
    end
  end

  // Bus FSM next state and DATA_OUT wait counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = wait_cnt_r;
    case (state_r)
      ST_IDLE, ST_OK, ST_ERR2: begin
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = acc_s ? tgt_s : ST_IDLE;
      end
      ST_WAIT: begin
        if (!busy_nxt_s) begin
          state_nxt_s = ST_OK;
        end else if (wait_cnt_r == CW'(MAX_WAIT - 1)) begin
          state_nxt_s = ST_ERR1;
        end else begin
          cnt_nxt_s = wait_cnt_r + CW'(1);
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read data is registered from next-cycle register values so the data phase sees them.
  always_comb begin
    hrdata_nxt_s = 64'd0;
    if ((state_nxt_s == ST_OK) && !rd_write_s) begin
      case (rd_addr_s)
        A_CTRL:  hrdata_nxt_s = {62'd0, decrypt_nxt_s, 1'b0};
        A_KEY1:  hrdata_nxt_s = key1_nxt_s;
        A_KEY2:  hrdata_nxt_s = key2_nxt_s;
        A_KEY3:  hrdata_nxt_s = key3_nxt_s;
        A_DIN:   hrdata_nxt_s = din_nxt_s;
        A_DOUT:  hrdata_nxt_s = dout_nxt_s;
        A_STAT:  hrdata_nxt_s = {61'd0, sticky_nxt_s, valid_nxt_s, busy_nxt_s};
        default: hrdata_nxt_s = 64'd0;
      endcase
    end else begin
      hrdata_nxt_s = 64'd0;
    end
  end

  // State, register file and registered bus/core outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= {CW{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      write_r     <= 1'b0;
      key1_r      <= 64'd0;
      key2_r      <= 64'd0;
      key3_r      <= 64'd0;
      din_r       <= 64'd0;
      dout_r      <= 64'd0;
      decrypt_r   <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      sticky_r    <= 1'b0;
      start_r     <= 1'b0;
      hrdata_r    <= 64'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= cnt_nxt_s;
      if (acc_s) begin
        addr_r  <= HADDR;
        write_r <= HWRITE;
      end
      key1_r      <= key1_nxt_s;
      key2_r      <= key2_nxt_s;
      key3_r      <= key3_nxt_s;
      din_r       <= din_nxt_s;
      dout_r      <= dout_nxt_s;
      decrypt_r   <= decrypt_nxt_s;
      busy_r      <= busy_nxt_s;
      valid_r     <= valid_nxt_s;
      sticky_r    <= sticky_nxt_s;
      start_r     <= start_nxt_s;
      hrdata_r    <= hrdata_nxt_s;
      hreadyout_r <= (state_nxt_s != ST_WAIT) && (state_nxt_s != ST_ERR1);
      hresp_r     <= (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
    end
  end

  assign HRDATA      = hrdata_r;
  assign HREADYOUT   = hreadyout_r;
  assign HRESP       = hresp_r;
  assign des_key1    = key1_r;
  assign des_key2    = key2_r;
  assign des_key3    = key3_r;
  assign des_data_in = din_r;
  assign des_decrypt = decrypt_r;
  assign des_start   = start_r;

endmodule

// File: tb/tb_ahb_des_slave.sv
// Scoreboard bench for ahb_des_slave: directed AHB transfers push expected responses,
// a negedge monitor pops and compares them as each data phase completes.
module tb_ahb_des_slave;

  localparam int MAX_WAIT = 64;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        hready;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] des_key1, des_key2, des_key3, des_data_in, des_data_out;
  logic        des_decrypt, des_start, des_done;

  typedef struct {
    logic        is_read;
    logic [63:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc_cnt = 0;

  assign hready = HREADYOUT;

  ahb_des_slave #(.ADDR_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(hready), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .des_key1(des_key1), .des_key2(des_key2),
    .des_key3(des_key3), .des_data_in(des_data_in), .des_decrypt(des_decrypt),
    .des_start(des_start), .des_data_out(des_data_out), .des_done(des_done)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    forever begin
      @(posedge HCLK);
      cyc_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: tracks data phases on the bus and scores each one on completion.
  initial begin
    logic dp_active;
    logic prev_resp;
    int   waits;
    exp_t e;
    dp_active = 1'b0;
    prev_resp = 1'b0;
    waits     = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_active = 1'b0;
      end else begin
        if (des_start) begin
          if (start_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
          else chk("start_cycle", 64'(cyc_cnt), 64'(start_q.pop_front()));
        end
        if (dp_active) begin
          if (HREADYOUT) begin
            dp_active = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_xfer", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("hresp", 64'(HRESP), 64'(e.resp));
              chk("wait_states", 64'(waits), 64'(e.waits));
              if (e.resp) chk("err_first_cycle_resp", 64'(prev_resp), 64'd1);
              else if (e.is_read) chk("hrdata", HRDATA, e.rdata);
            end
          end else begin
            waits++;
          end
        end
        if (HSEL && hready && HTRANS[1]) begin
          dp_active = 1'b1;
          waits     = 0;
        end
      end
      prev_resp = HRESP;
    end
  end

  // One non-pipelined transfer; optionally pulses des_done done_at cycles into the data phase.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [2:0] sz,
                      input logic [63:0] wd, input logic [63:0] ed, input logic er,
                      input int ew, input int done_at, input logic [63:0] dv);
    exp_t e;
    int   cyc;
    logic exp_start;
    e.is_read = !w;
    e.rdata   = ed;
    e.resp    = er;
    e.waits   = ew;
    exp_q.push_back(e);
    exp_start = w && !er && (a == 8'h00) && wd[0];
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = w ? wd : 64'd0;
    cyc = 0;
    while (1) begin
      des_done     = (cyc == done_at);
      des_data_out = dv;
      @(negedge HCLK);
      if (HREADYOUT) break;
      @(posedge HCLK); #1;
      cyc++;
      if (cyc > 200) begin
        n_total++;
        $display("FAIL timeout: data phase at 0x%h still waiting after %0d cycles", a, cyc);
        break;
      end
    end
    if (exp_start) start_q.push_back(cyc_cnt + 1);
    @(posedge HCLK); #1;
    des_done = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic er);
    xfer(1'b1, a, 3'b011, d, 64'd0, er, er ? 1 : 0, -1, 64'd0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [63:0] ed);
    xfer(1'b0, a, 3'b011, 64'd0, ed, 1'b0, 0, -1, 64'd0);
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 8'h00; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b011; HWDATA = 64'd0; des_data_out = 64'd0; des_done = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp", 64'(HRESP), 64'd0);
    chk("rst_hrdata", HRDATA, 64'd0);
    chk("rst_des_start", 64'(des_start), 64'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    wr(8'h08, 64'h0123456789ABCDEF, 1'b0);
    rd(8'h08, 64'h0123456789ABCDEF);
    wr(8'h20, 64'h1122334455667788, 1'b0);
    rd(8'h20, 64'h1122334455667788);
    wr(8'h00, 64'h1, 1'b0);
    rd(8'h30, 64'h1);
    rd(8'h00, 64'h0);
    xfer(1'b0, 8'h28, 3'b011, 64'd0, 64'hABCDEF1234567890, 1'b0, 6, 5, 64'hABCDEF1234567890);
    rd(8'h30, 64'h2);

    wr(8'h38, 64'h5555, 1'b1);
    xfer(1'b1, 8'h08, 3'b010, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 1, -1, 64'd0);
    xfer(1'b0, 8'h04, 3'b011, 64'd0, 64'd0, 1'b1, 1, -1, 64'd0);
    wr(8'h00, 64'h3, 1'b0);
    wr(8'h10, 64'h1111111111111111, 1'b1);
    rd(8'h30, 64'h5);
    rd(8'h30, 64'h1);
    rd(8'h08, 64'h0123456789ABCDEF);
    rd(8'h10, 64'h0);
    rd(8'h00, 64'h2);

    xfer(1'b0, 8'h28, 3'b011, 64'd0, 64'd0, 1'b1, MAX_WAIT + 1, -1, 64'd0);
    rd(8'h30, 64'h5);

    // DATA_OUT read while still busy, aborted by reset in the middle of the wait.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 8'h28; HWRITE = 1'b0; HSIZE = 3'b011;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (3) @(posedge HCLK);
    #1;
    chk("in_wait_hreadyout", 64'(HREADYOUT), 64'd0);
    HRESETn = 1'b0;
    #1;
    chk("midrst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("midrst_hresp", 64'(HRESP), 64'd0);
    chk("midrst_hrdata", HRDATA, 64'd0);
    chk("midrst_key1", des_key1, 64'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    des_done = 1'b1; des_data_out = 64'hDEADBEEFDEADBEEF;
    @(posedge HCLK); #1;
    des_done = 1'b0;
    rd(8'h28, 64'h0);
    rd(8'h30, 64'h0);
    rd(8'h08, 64'h0);

    repeat (4) @(posedge HCLK);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("start_q_drained", 64'(start_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
